// File: rtl/addr_alu_datapath_pkg.sv
// Shared definitions for the address/ALU datapath slice: widths, ALU function
// codes, address-low base/offset selects, address-high base selects, constants.
package addr_alu_datapath_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 16;

  // ALU function codes
  localparam logic [4:0] ALU_PASS_R = 5'h00;
  localparam logic [4:0] ALU_PASS_M = 5'h01;
  localparam logic [4:0] ALU_OR     = 5'h02;
  localparam logic [4:0] ALU_AND    = 5'h03;
  localparam logic [4:0] ALU_XOR    = 5'h04;
  localparam logic [4:0] ALU_ADC    = 5'h05;
  localparam logic [4:0] ALU_SBC    = 5'h06;
  localparam logic [4:0] ALU_ROL_M  = 5'h07;
  localparam logic [4:0] ALU_ROR_M  = 5'h08;
  localparam logic [4:0] ALU_ROL_R  = 5'h09;
  localparam logic [4:0] ALU_ROR_R  = 5'h0A;
  localparam logic [4:0] ALU_BIC    = 5'h0B;

  // Address-low base selects (abl_op[4:2])
  localparam logic [2:0] ABL_B_ABL = 3'd0;
  localparam logic [2:0] ABL_B_PCL = 3'd1;
  localparam logic [2:0] ABL_B_DB  = 3'd2;
  localparam logic [2:0] ABL_B_AHL = 3'd3;
  localparam logic [2:0] ABL_B_REG = 3'd4;

  // Address-low offset selects (abl_op[1:0])
  localparam logic [1:0] ABL_O_ZERO = 2'd0;
  localparam logic [1:0] ABL_O_REG  = 2'd1;
  localparam logic [1:0] ABL_O_DB   = 2'd2;

  // Address-high base selects (abh_op[3:1])
  localparam logic [2:0] ABH_B_ABH  = 3'd0;
  localparam logic [2:0] ABH_B_PCH  = 3'd1;
  localparam logic [2:0] ABH_B_DB   = 3'd2;
  localparam logic [2:0] ABH_B_ZP   = 3'd3;
  localparam logic [2:0] ABH_B_STK  = 3'd4;
  localparam logic [2:0] ABH_B_VEC  = 3'd5;

  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_01 = 8'h01;
  localparam logic [7:0] BYTE_FF = 8'hFF;

endpackage

// File: rtl/addr_alu_datapath_if.sv
// Sequencer <-> datapath bundle: microcode control fields, operand buses and
// the datapath results (address bus, PC, ALU result and flags).
// master: sequencer side; slave: datapath side.
interface addr_alu_datapath_if;
  import addr_alu_datapath_pkg::*;

  logic [4:0]        abl_op;
  logic              abl_ci;
  logic [3:0]        abh_op;
  logic              ld_ahl;
  logic              ld_pc;
  logic              inc_pc;
  logic [DATA_W-1:0] DB;
  logic [DATA_W-1:0] REG;
  logic [DATA_W-1:0] M;
  logic [4:0]        alu_op;
  logic              alu_ci;
  logic              alu_si;
  logic [ADDR_W-1:0] AD;
  logic [ADDR_W-1:0] PC;
  logic [DATA_W-1:0] alu_out;
  logic              alu_co;
  logic              alu_v;
  logic              adjh;
  logic              adjl;

  modport master (
    output abl_op, abl_ci, abh_op, ld_ahl, ld_pc, inc_pc, DB, REG, M,
           alu_op, alu_ci, alu_si,
    input  AD, PC, alu_out, alu_co, alu_v, adjh, adjl
  );

  modport slave (
    input  abl_op, abl_ci, abh_op, ld_ahl, ld_pc, inc_pc, DB, REG, M,
           alu_op, alu_ci, alu_si,
    output AD, PC, alu_out, alu_co, alu_v, adjh, adjl
  );
endinterface

// File: rtl/addr_alu_datapath_dp_alu.sv
// dp_alu: purely combinational 8-bit ALU.
// Ports: op (function code), r/m operands, ci carry in, si shift-in;
//        out_c result, co_c carry, v_c signed overflow, adjh_c/adjl_c BCD adjust.
// Macro ALU_BCD_EN: when defined, adjh_c/adjl_c are generated; otherwise tied 0
// and the half-carry adder is not built.
module dp_alu
  import addr_alu_datapath_pkg::*;
(
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] r,
  input  logic [DATA_W-1:0] m,
  input  logic              ci,
  input  logic              si,
  output logic [DATA_W-1:0] out_c,
  output logic              co_c,
  output logic              v_c,
  output logic              adjh_c,
  output logic              adjl_c
);

  logic [DATA_W-1:0] b_opnd;
  logic [DATA_W:0]   sum;
`ifdef ALU_BCD_EN
  logic [4:0]        half;
`endif

  always_comb begin
    // Subtract is R + ~M + ci; one adder serves both arithmetic codes
    b_opnd = (op == ALU_SBC) ? ~m : m;
    sum    = {1'b0, r} + {1'b0, b_opnd} + 9'(ci);
    out_c  = r;
    co_c   = 1'b0;
    v_c    = 1'b0;
    adjh_c = 1'b0;
    adjl_c = 1'b0;
    case (op)
      ALU_PASS_R: out_c = r;
      ALU_PASS_M: out_c = m;
      ALU_OR:     out_c = r | m;
      ALU_AND:    out_c = r & m;
      ALU_XOR:    out_c = r ^ m;
      ALU_ADC, ALU_SBC: begin
        out_c = sum[7:0];
        co_c  = sum[8];
        v_c   = (r[7] == b_opnd[7]) && (sum[7] != r[7]);
      end
      ALU_ROL_M: begin out_c = {m[6:0], si}; co_c = m[7]; end
      ALU_ROR_M: begin out_c = {si, m[7:1]}; co_c = m[0]; end
      ALU_ROL_R: begin out_c = {r[6:0], si}; co_c = r[7]; end
      ALU_ROR_R: begin out_c = {si, r[7:1]}; co_c = r[0]; end
      ALU_BIC:    out_c = ~r & m;
      default: ;
    endcase
`ifdef ALU_BCD_EN
    half = {1'b0, r[3:0]} + {1'b0, b_opnd[3:0]} + 5'(ci);
    if (op == ALU_ADC) begin
      adjl_c = half[4] | (sum[3:0] > 4'd9);
      adjh_c = sum[8] | (sum[7:0] > 8'h99);
    end else if (op == ALU_SBC) begin
      adjl_c = ~half[4];
      adjh_c = ~sum[8];
    end
`endif
  end

endmodule

// File: rtl/addr_alu_datapath.sv
// addr_alu_datapath: 65C02-class address generator (ABL/ABH/PC/AHL) plus ALU.
// Ports: clk, RST (synchronous, active-high), bus (slave modport) carrying the
//        microcode controls, DB/REG/M operands, combinational AD and ALU
//        outputs, and the registered PC.
// Macro ALU_BCD_EN: enables the BCD adjust outputs of the ALU.
module addr_alu_datapath
  import addr_alu_datapath_pkg::*;
(
  input  logic                 clk,
  input  logic                 RST,
  addr_alu_datapath_if.slave   bus
);

  logic [DATA_W-1:0] abl, abh, pcl, pch, ahl;
  logic [DATA_W-1:0] adl_base, adl_off, adh_base, adl, adh;
  logic [DATA_W:0]   adl_sum, pcl_sum;
  logic              abl_co;
  logic [DATA_W-1:0] pch_next;
  logic [DATA_W-1:0] alu_out_c;
  logic              alu_co_c, alu_v_c, adjh_c, adjl_c;

  // Address-low/high generation
  always_comb begin
    adl_base = BYTE_00;
    case (bus.abl_op[4:2])
      ABL_B_ABL: adl_base = abl;
      ABL_B_PCL: adl_base = pcl;
      ABL_B_DB:  adl_base = bus.DB;
      ABL_B_AHL: adl_base = ahl;
      ABL_B_REG: adl_base = bus.REG;
      default:   adl_base = BYTE_00;
    endcase
    adl_off = BYTE_00;
    case (bus.abl_op[1:0])
      ABL_O_REG: adl_off = bus.REG;
      ABL_O_DB:  adl_off = bus.DB;
      default:   adl_off = BYTE_00;
    endcase
    adl_sum = {1'b0, adl_base} + {1'b0, adl_off} + 9'(bus.abl_ci);
    adl     = adl_sum[7:0];
    abl_co  = adl_sum[8];
    adh_base = abh;
    case (bus.abh_op[3:1])
      ABH_B_PCH: adh_base = pch;
      ABH_B_DB:  adh_base = bus.DB;
      ABH_B_ZP:  adh_base = BYTE_00;
      ABH_B_STK: adh_base = BYTE_01;
      ABH_B_VEC: adh_base = BYTE_FF;
      default:   adh_base = abh;
    endcase
    // Page carry only propagates when the microcode asks for it
    adh = adh_base + 8'(bus.abh_op[0] & abl_co);
  end

  // PC next value: optional load from AD, then optional 16-bit increment
  always_comb begin
    pcl_sum  = {1'b0, (bus.ld_pc ? adl : pcl)} + 9'(bus.inc_pc);
    pch_next = (bus.ld_pc ? adh : pch) + 8'(pcl_sum[8]);
  end

  // Address, AHL and PC registers
  always_ff @(posedge clk) begin
    if (RST) begin
      abl <= BYTE_00;
      abh <= BYTE_00;
      pcl <= BYTE_00;
      pch <= BYTE_00;
      ahl <= BYTE_00;
    end else begin
      abl <= adl;
      abh <= adh;
      pcl <= pcl_sum[7:0];
      pch <= pch_next;
      if (bus.ld_ahl) ahl <= bus.DB;
    end
  end

  dp_alu u_alu (
    .op     (bus.alu_op),
    .r      (bus.REG),
    .m      (bus.M),
    .ci     (bus.alu_ci),
    .si     (bus.alu_si),
    .out_c  (alu_out_c),
    .co_c   (alu_co_c),
    .v_c    (alu_v_c),
    .adjh_c (adjh_c),
    .adjl_c (adjl_c)
  );

  assign bus.AD      = {adh, adl};
  assign bus.PC      = {pch, pcl};
  assign bus.alu_out = alu_out_c;
  assign bus.alu_co  = alu_co_c;
  assign bus.alu_v   = alu_v_c;
  assign bus.adjh    = adjh_c;
  assign bus.adjl    = adjl_c;

endmodule

// File: tb/tb_addr_alu_datapath.sv
// Bench for addr_alu_datapath: directed address/PC sequences, an ALU vector
// table, and random cycles compared against an arithmetic reference model.
module tb_addr_alu_datapath;

`ifdef ALU_BCD_EN
  localparam bit BCD_ON = 1'b1;
`else
  localparam bit BCD_ON = 1'b0;
`endif

  logic clk;
  logic RST;
  int   n_pass;
  int   n_total;

  addr_alu_datapath_if bus();

  addr_alu_datapath u_dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Reference model state
  int m_abl, m_abh, m_ahl, m_pc;
  bit model_valid;

  typedef struct {
    int out;
    bit co;
    bit v;
    bit adjh;
    bit adjl;
  } alu_res_t;

  typedef struct {
    logic [4:0] op;
    logic [7:0] r;
    logic [7:0] m;
    logic       ci;
    logic       si;
    logic [7:0] out;
    logic       co;
    logic       v;
    logic       adjh;
    logic       adjl;
  } alu_vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int to_signed8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic alu_res_t ref_alu(input int op, input int r, input int m,
                                       input int ci, input int si);
    alu_res_t res;
    int b, s, sv;
    bit hc;
    res.out = r; res.co = 0; res.v = 0; res.adjh = 0; res.adjl = 0;
    case (op)
      0: res.out = r;
      1: res.out = m;
      2: res.out = r | m;
      3: res.out = r & m;
      4: res.out = r ^ m;
      5, 6: begin
        b = (op == 5) ? m : 255 - m;
        s = r + b + ci;
        res.out = s % 256;
        res.co  = (s > 255);
        sv = to_signed8(r) + to_signed8(b) + ci;
        res.v = (sv > 127) || (sv < -128);
        hc = ((r % 16) + (b % 16) + ci) > 15;
        if (BCD_ON) begin
          if (op == 5) begin
            res.adjl = hc || ((res.out % 16) > 9);
            res.adjh = res.co || (res.out > 153);
          end else begin
            res.adjl = !hc;
            res.adjh = !res.co;
          end
        end
      end
      7:  begin res.out = (m * 2) % 256 + si; res.co = (m >= 128); end
      8:  begin res.out = si * 128 + m / 2;   res.co = (m % 2) == 1; end
      9:  begin res.out = (r * 2) % 256 + si; res.co = (r >= 128); end
      10: begin res.out = si * 128 + r / 2;   res.co = (r % 2) == 1; end
      11: res.out = (255 - r) & m;
      default: res.out = r;
    endcase
    return res;
  endfunction

  // Model address: returns {adh,adl} as a 16-bit number
  function automatic int model_ad();
    int bl, off, hb, s, adh;
    int db, rg;
    db = int'(bus.DB);
    rg = int'(bus.REG);
    case (int'(bus.abl_op[4:2]))
      0: bl = m_abl;
      1: bl = m_pc % 256;
      2: bl = db;
      3: bl = m_ahl;
      4: bl = rg;
      default: bl = 0;
    endcase
    case (int'(bus.abl_op[1:0]))
      1: off = rg;
      2: off = db;
      default: off = 0;
    endcase
    case (int'(bus.abh_op[3:1]))
      1: hb = m_pc / 256;
      2: hb = db;
      3: hb = 0;
      4: hb = 1;
      5: hb = 255;
      default: hb = m_abh;
    endcase
    s = bl + off + int'(bus.abl_ci);
    adh = (hb + ((bus.abh_op[0] && s > 255) ? 1 : 0)) % 256;
    return adh * 256 + (s % 256);
  endfunction

  // Compare combinational outputs with the model (after inputs settle)
  task automatic pre_check();
    alu_res_t e;
    #1;
    if (model_valid) begin
      check("AD", bus.AD, 16'(model_ad()));
      e = ref_alu(int'(bus.alu_op), int'(bus.REG), int'(bus.M),
                  int'(bus.alu_ci), int'(bus.alu_si));
      check("alu_out", 16'(bus.alu_out), 16'(e.out));
      check("alu_co",  16'(bus.alu_co),  16'(e.co));
      check("alu_v",   16'(bus.alu_v),   16'(e.v));
      check("adjh",    16'(bus.adjh),    16'(e.adjh));
      check("adjl",    16'(bus.adjl),    16'(e.adjl));
    end
  endtask

  // Advance one clock and update the model; check PC against it
  task automatic tick();
    int ad, n_abl, n_abh, n_ahl, n_pc;
    ad = model_ad();
    if (RST) begin
      n_abl = 0; n_abh = 0; n_ahl = 0; n_pc = 0;
    end else begin
      n_abl = ad % 256;
      n_abh = ad / 256;
      n_ahl = bus.ld_ahl ? int'(bus.DB) : m_ahl;
      n_pc  = ((bus.ld_pc ? ad : m_pc) + int'(bus.inc_pc)) % 65536;
    end
    @(posedge clk);
    #1;
    m_abl = n_abl; m_abh = n_abh; m_ahl = n_ahl; m_pc = n_pc;
    if (RST) model_valid = 1'b1;
    if (model_valid) check("PC", bus.PC, 16'(m_pc));
  endtask

  task automatic drive(input logic [4:0] ablop, input logic ablci, input logic [3:0] abhop,
                       input logic ldahl, input logic ldpc, input logic incpc,
                       input logic [7:0] db, input logic [7:0] rg);
    @(negedge clk);
    bus.abl_op = ablop; bus.abl_ci = ablci; bus.abh_op = abhop;
    bus.ld_ahl = ldahl; bus.ld_pc = ldpc; bus.inc_pc = incpc;
    bus.DB = db; bus.REG = rg;
  endtask

  alu_vec_t vecs[17];

  initial begin
    n_pass = 0; n_total = 0; model_valid = 1'b0;
    m_abl = 0; m_abh = 0; m_ahl = 0; m_pc = 0;
    RST = 1'b1;
    bus.abl_op = '0; bus.abl_ci = 1'b0; bus.abh_op = '0;
    bus.ld_ahl = 1'b0; bus.ld_pc = 1'b0; bus.inc_pc = 1'b0;
    bus.DB = '0; bus.REG = '0; bus.M = '0;
    bus.alu_op = '0; bus.alu_ci = 1'b0; bus.alu_si = 1'b0;

    //            op     R      M      ci    si    OUT    CO    V     ADJH  ADJL (BCD build)
    vecs[0]  = '{5'h05, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{5'h06, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{5'h07, 8'h00, 8'h80, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5'h05, 8'h19, 8'h28, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{5'h05, 8'h99, 8'h01, 1'b0, 1'b0, 8'h9A, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{5'h02, 8'h0F, 8'hF0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{5'h03, 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{5'h04, 8'hAA, 8'hFF, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{5'h08, 8'h00, 8'h01, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{5'h09, 8'h81, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{5'h0A, 8'h02, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{5'h0B, 8'hF0, 8'hFF, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{5'h00, 8'h5A, 8'hA5, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{5'h01, 8'h5A, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{5'h1F, 8'h33, 8'hCC, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{5'h05, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[16] = '{5'h06, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset overrides ld_pc/inc_pc/ld_ahl
    drive(5'b00000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 8'h55, 8'h00);
    pre_check(); tick();
    check("rst_pc", bus.PC, 16'h0000);
    RST = 1'b0;
    drive(5'b00000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    pre_check(); check("rst_abl_abh", bus.AD, 16'h0000); tick();
    drive(5'b01100, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    pre_check(); check("rst_ahl", bus.AD, 16'h0000); tick();
    drive(5'b00100, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    pre_check(); check("rst_ad_pc", bus.AD, 16'h0000); tick();

    // Load PC=0x12FF, then fetch increment across the page
    drive(5'b00000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00);
    pre_check(); tick();
    drive(5'b01100, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 8'h12, 8'h00);
    pre_check(); check("ld_ad", bus.AD, 16'h12FF); tick();
    check("ld_pc", bus.PC, 16'h12FF);
    drive(5'b00100, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    pre_check(); check("fetch_ad", bus.AD, 16'h12FF); tick();
    check("fetch_pc", bus.PC, 16'h1300);

    // Indexed zero page, with and without page carry
    drive(5'b01001, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 8'hF0, 8'h20);
    pre_check(); check("zp_carry", bus.AD, 16'h0110); tick();
    drive(5'b01001, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 8'hF0, 8'h20);
    pre_check(); check("zp_wrap", bus.AD, 16'h0010); tick();
    // Stack page: REG+ci carries into 0x01 -> 0x0200
    drive(5'b10000, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF);
    pre_check(); check("stack_carry", bus.AD, 16'h0200); tick();

    // Vector fetch then jump via AHL
    drive(5'b10000, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFC);
    pre_check(); check("vector", bus.AD, 16'hFFFC); tick();
    drive(5'b00000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 8'h34, 8'h00);
    pre_check(); tick();
    drive(5'b01100, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 8'h12, 8'h00);
    pre_check(); check("jump_ad", bus.AD, 16'h1234); tick();
    check("jump_pc", bus.PC, 16'h1234);

    // PC wrap at 0xFFFF
    drive(5'b10000, 1'b0, 4'b1010, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF);
    pre_check(); tick();
    check("pc_ffff", bus.PC, 16'hFFFF);
    drive(5'b00100, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    pre_check(); tick();
    check("pc_wrap", bus.PC, 16'h0000);

    // ALU vector table
    for (int i = 0; i < 17; i++) begin
      drive(5'b00000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, vecs[i].r);
      bus.alu_op = vecs[i].op; bus.M = vecs[i].m;
      bus.alu_ci = vecs[i].ci; bus.alu_si = vecs[i].si;
      pre_check();
      check($sformatf("vec%0d_out", i), 16'(bus.alu_out), 16'(vecs[i].out));
      check($sformatf("vec%0d_co", i),  16'(bus.alu_co),  16'(vecs[i].co));
      check($sformatf("vec%0d_v", i),   16'(bus.alu_v),   16'(vecs[i].v));
      check($sformatf("vec%0d_adjh", i), 16'(bus.adjh), 16'(vecs[i].adjh & BCD_ON));
      check($sformatf("vec%0d_adjl", i), 16'(bus.adjl), 16'(vecs[i].adjl & BCD_ON));
      tick();
    end

    // Random cycles against the model
    for (int i = 0; i < 400; i++) begin
      drive(5'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 8'($urandom), 8'($urandom));
      RST = ($urandom_range(0, 15) == 0);
      bus.alu_op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 11));
      bus.M = 8'($urandom); bus.alu_ci = 1'($urandom); bus.alu_si = 1'($urandom);
      pre_check();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/addr_alu_datapath.md
Name: addr_alu_datapath

Overview:
- 65C02-class CPU datapath slice: address-bus generator (low and high byte, program counter, temporary address byte) plus 8-bit ALU.
- Controlled each cycle by microcode fields from the sequencer.
- Produces the combinational 16-bit address bus, the PC, and the ALU result, carry, overflow and BCD-adjust outputs consumed by the register file, flag logic and data-out mux.

Parameters:
- none. Width is fixed at 8-bit data and 16-bit address.

Ports:
- clk  in  1  CPU clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- abl_op  in  5  address-low select: [4:2] base, [1:0] offset.
- abl_ci  in  1  carry into address-low adder.
- abh_op  in  4  address-high select: [3:1] base, [0] carry-propagate enable.
- ld_ahl  in  1  load AHL from DB.
- ld_pc  in  1  load PC from current address.
- inc_pc  in  1  increment PC.
- DB  in  8  data bus input.
- REG  in  8  register-file read value; also ALU operand R.
- M  in  8  registered memory operand for the ALU.
- alu_op  in  5  ALU function code.
- alu_ci  in  1  ALU carry in.
- alu_si  in  1  ALU shift-in bit.
- AD  out  16  address bus {ADH,ADL}, combinational.
- PC  out  16  program counter {PCH,PCL}.
- alu_out  out  8  ALU result, combinational.
- alu_co  out  1  ALU carry out.
- alu_v  out  1  signed overflow.
- adjh, adjl  out  1 each  BCD adjust requests, high and low nibble.

Behaviour:
- State: ABL, ABH (previous address), PCL, PCH, AHL; all 8-bit.
- RST high at a clock edge: all five registers <= 0x00. RST overrides every load and increment.
- ADL = base + offset + abl_ci, modulo 256. abl_co is the carry out of this add.
- ADL base codes 0..7: ABL, PCL, DB, AHL, REG, 0x00, 0x00, 0x00.
- ADL offset codes 0..3: 0x00, REG, DB, 0x00.
- ADH = base + (abh_op[0] & abl_co), modulo 256. ADH has no carry out.
- ADH base codes 0..7: ABH, PCH, DB, 0x00 (zero page), 0x01 (stack), 0xFF (vectors), ABH, ABH.
- Every cycle: ABL <= ADL, ABH <= ADH.
- ld_ahl: AHL <= DB.
- PC update: PCL <= (ld_pc ? ADL : PCL) + inc_pc. pcl_co is the carry of that add. PCH <= (ld_pc ? ADH : PCH) + pcl_co.
- PC wrap: PC 0xFFFF with inc_pc goes to 0x0000.
- ALU codes (R = REG):
  - 0x00 OUT=R
  - 0x01 OUT=M
  - 0x02 R|M
  - 0x03 R&M
  - 0x04 R^M
  - 0x05 R+M+ci
  - 0x06 R+~M+ci
  - 0x07 OUT={M[6:0],si}, CO=M[7]
  - 0x08 OUT={si,M[7:1]}, CO=M[0]
  - 0x09 OUT={R[6:0],si}, CO=R[7]
  - 0x0A OUT={si,R[7:1]}, CO=R[0]
  - 0x0B ~R&M
  - other codes: OUT=R.
- CO is 0 for all logic and pass codes.
- V for codes 0x05 and 0x06 is two's-complement overflow of the effective addition; V=0 for all other codes.
- BCD adjust, code 0x05 only:
  - adjl = low-nibble carry OR low nibble of OUT > 9.
  - adjh = CO OR OUT > 0x99.
- BCD adjust, code 0x06 only: adjl = NOT low-nibble carry; adjh = NOT CO.
- BCD adjust is 0 for all other codes.
- Latency: AD and alu_* are combinational in the same cycle. Registers update one cycle later.

Optional Feature:
- Macro ALU_BCD_EN.
- Defined: adjh/adjl are computed as above.
- Undefined: adjh = adjl = 0 and the half-carry logic is removed. Binary results are unchanged.

Decomposition:
- Shared package holds:
  - ALU op code localparams
  - ABL base/offset codes
  - ABH base codes
  - constants 0x00, 0x01, 0xFF
- One sub-module is natural: dp_alu (pure combinational ALU). Address and PC logic stays in the top.

Test Plan:
- Reset: RST=1 for one cycle with ld_pc=1 -> PC=0x0000, AHL=0x00; next cycle AD=0x0000 with base PC/PC.
- Fetch increment: PC=0x12FF, abl base PCL, abh base PCH, inc_pc=1 -> AD=0x12FF, next PC=0x1300.
- Indexed zero page: DB=0xF0, REG=0x20, abl base DB, offset REG, abh code zero page with carry enabled -> AD=0x0110.
- Vector and jump: REG=0xFC, abh 0xFF -> AD=0xFFFC. Then ld_ahl with DB=0x34, next cycle ADL=AHL, ADH=DB=0x12, ld_pc -> PC=0x1234.
- ALU: ADD R=0x7F M=0x01 ci=0 -> OUT=0x80, V=1, CO=0. SUB R=0x00 M=0x01 ci=1 -> OUT=0xFF, CO=0. ROL M=0x80 si=1 -> OUT=0x01, CO=1.
- BCD (ALU_BCD_EN defined): ADD R=0x19 M=0x28 -> OUT=0x41, adjl=1, adjh=0. ADD R=0x99 M=0x01 -> adjl=1, adjh=1. Without the macro both are 0.
